// File: rtl/ysyx_22040931_inst_fetch_if.sv
// Signal bundle of the fetch stage: PC offer from upstream, instruction-memory
// read request/response channels and the instruction handoff toward decode.
interface ysyx_22040931_inst_fetch_if #(
  parameter int PC_W  = 64,
  parameter int BUS_W = 64
);
  logic             pc_valid;
  logic [PC_W-1:0]  pc_in;
  logic             if_ready;
  logic             flush;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [PC_W-1:0]  mem_req_addr;

  logic             mem_rsp_valid;
  logic [BUS_W-1:0] mem_rsp_data;
  logic             mem_rsp_err;
  logic             mem_rsp_ready;

  logic             id_valid;
  logic             id_ready;
  logic [PC_W-1:0]  id_pc;
  logic [31:0]      id_inst;
  logic [1:0]       id_exc;

  modport master (
    input  pc_valid, pc_in, flush,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           id_ready,
    output if_ready, mem_req_valid, mem_req_addr, mem_rsp_ready,
           id_valid, id_pc, id_inst, id_exc
  );

  modport slave (
    output pc_valid, pc_in, flush,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           id_ready,
    input  if_ready, mem_req_valid, mem_req_addr, mem_rsp_ready,
           id_valid, id_pc, id_inst, id_exc
  );
endinterface

// File: rtl/ysyx_22040931_inst_fetch.sv
// Single-outstanding instruction fetch stage: takes a PC, reads the aligned
// 64-bit word, picks the 32-bit half and holds it for decode; flush kills work.
module ysyx_22040931_inst_fetch #(
  parameter int PC_W  = 64,
  parameter int BUS_W = 64
) (
  input logic clock,
  input logic reset,
  ysyx_22040931_inst_fetch_if.master bus
);
  localparam int HALF = BUS_W / 2;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t          state;
  logic            kill;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_addr;
  logic [31:0]     inst_q;
  logic [1:0]      exc_q;

  logic            ready_out;
  logic            accept;
  logic            misaligned;
  logic [31:0]     rsp_word;

  assign ready_out  = !bus.flush && ((state == IDLE) || (state == HOLD && bus.id_ready));
  assign accept     = bus.pc_valid && ready_out;
  assign misaligned = bus.pc_in[1:0] != 2'b00;
  assign rsp_word   = pc_q[2] ? bus.mem_rsp_data[BUS_W-1:HALF] : bus.mem_rsp_data[HALF-1:0];

  assign bus.if_ready      = ready_out;
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_req_addr  = req_addr;
  assign bus.mem_rsp_ready = (state == WAIT) || (state == DROP);
  assign bus.id_valid      = (state == HOLD) && !bus.flush;
  assign bus.id_pc         = pc_q;
  assign bus.id_inst       = inst_q;
  assign bus.id_exc        = exc_q;

  // A flushed request is never withdrawn; kill steers its response into DROP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      kill     <= 1'b0;
      pc_q     <= '0;
      req_addr <= '0;
      inst_q   <= '0;
      exc_q    <= 2'b00;
    end else if (accept) begin
      pc_q <= bus.pc_in;
      if (misaligned) begin
        state  <= HOLD;
        exc_q  <= 2'b01;
        inst_q <= 32'h0000_0013;
      end else begin
        state    <= REQ;
        exc_q    <= 2'b00;
        req_addr <= {bus.pc_in[PC_W-1:3], 3'b000};
      end
    end else begin
      case (state)
        IDLE: ;
        REQ: begin
          if (bus.flush) kill <= 1'b1;
          if (bus.mem_req_ready) state <= (kill || bus.flush) ? DROP : WAIT;
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (bus.flush) begin
              state <= IDLE;
            end else begin
              state  <= HOLD;
              inst_q <= rsp_word;
              exc_q  <= bus.mem_rsp_err ? 2'b10 : 2'b00;
            end
          end else if (bus.flush) begin
            state <= DROP;
            kill  <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.flush || bus.id_ready) state <= IDLE;
        end
        DROP: begin
          if (bus.mem_rsp_valid) begin
            state <= IDLE;
            kill  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040931_inst_fetch.sv
// Self-checking bench for the fetch stage: directed scenarios then randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_ysyx_22040931_inst_fetch;
  logic clock;
  logic reset;

  ysyx_22040931_inst_fetch_if #(.PC_W(64), .BUS_W(64)) bus ();
  ysyx_22040931_inst_fetch #(.PC_W(64), .BUS_W(64)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic        drv_pc_valid  = 1'b0;
  logic [63:0] drv_pc        = '0;
  logic        drv_flush     = 1'b0;
  logic        drv_id_ready  = 1'b0;
  logic        drv_req_ready = 1'b0;
  logic        drv_stray     = 1'b0;
  int          delay_cfg     = 0;
  int          err_cfg       = 0;

  // Reference: one accepted PC is outstanding until delivered or flushed.
  logic        pend_valid    = 1'b0;
  logic        pend_ready    = 1'b0;
  logic [63:0] pend_pc       = '0;
  logic [31:0] pend_inst     = '0;
  logic [1:0]  pend_exc      = '0;
  logic        req_expected  = 1'b0;
  logic [63:0] req_addr      = '0;
  logic        mem_busy      = 1'b0;
  logic [63:0] mem_addr      = '0;
  int          mem_delay     = 0;
  logic        mem_err       = 1'b0;

  logic        seen_idv;
  logic        seen_ifr;

  function automatic logic [63:0] memData(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00500093_00100073;
    return {a[31:0] ^ 32'hdead_beef, ~a[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearDrive();
    drv_pc_valid  = 1'b0;
    drv_flush     = 1'b0;
    drv_id_ready  = 1'b0;
    drv_req_ready = 1'b0;
    drv_stray     = 1'b0;
    bus.pc_valid      = 1'b0;
    bus.pc_in         = '0;
    bus.flush         = 1'b0;
    bus.id_ready      = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, sample just after, then advance the model.
  task automatic applyStimulus();
    logic        idle_model;
    logic        req_hs, rsp_hs, id_hs, acc;
    logic [63:0] d;
    @(negedge clock);
    bus.pc_valid      = drv_pc_valid;
    bus.pc_in         = drv_pc;
    bus.flush         = drv_flush;
    bus.id_ready      = drv_id_ready;
    bus.mem_req_ready = drv_req_ready;
    bus.mem_rsp_valid = mem_busy ? (mem_delay == 0) : drv_stray;
    bus.mem_rsp_data  = mem_busy ? memData(mem_addr) : {$urandom, $urandom};
    bus.mem_rsp_err   = mem_busy ? mem_err : 1'($urandom_range(0, 1));
    #1;
    idle_model = !pend_valid && !req_expected && !mem_busy;
    checkOutput("mem_req_valid", bus.mem_req_valid, req_expected);
    if (req_expected) checkOutput("mem_req_addr", bus.mem_req_addr, req_addr);
    checkOutput("mem_rsp_ready", bus.mem_rsp_ready, mem_busy);
    checkOutput("id_valid", bus.id_valid, pend_valid && pend_ready && !drv_flush);
    if (pend_valid && pend_ready) begin
      checkOutput("id_pc", bus.id_pc, pend_pc);
      checkOutput("id_exc", bus.id_exc, pend_exc);
      if (pend_exc != 2'b10) checkOutput("id_inst", bus.id_inst, pend_inst);
    end
    checkOutput("if_ready", bus.if_ready,
                !drv_flush && (idle_model || (pend_valid && pend_ready && drv_id_ready)));
    seen_idv = bus.id_valid;
    seen_ifr = bus.if_ready;

    acc    = drv_pc_valid && bus.if_ready;
    req_hs = bus.mem_req_valid && drv_req_ready;
    rsp_hs = mem_busy && bus.mem_rsp_valid && bus.mem_rsp_ready;
    id_hs  = bus.id_valid && drv_id_ready;

    if (mem_busy && !rsp_hs && mem_delay > 0) mem_delay--;
    if (rsp_hs) begin
      mem_busy = 1'b0;
      if (pend_valid && !drv_flush) begin
        d          = memData(mem_addr);
        pend_ready = 1'b1;
        pend_exc   = mem_err ? 2'b10 : 2'b00;
        pend_inst  = pend_pc[2] ? d[63:32] : d[31:0];
      end
    end
    if (req_hs) begin
      req_expected = 1'b0;
      mem_busy     = 1'b1;
      mem_addr     = req_addr;
      mem_delay    = (delay_cfg >= 0) ? delay_cfg : $urandom_range(0, 3);
      mem_err      = (err_cfg == 1) ? 1'b1 : (err_cfg == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
    if (id_hs || drv_flush) begin
      pend_valid = 1'b0;
      pend_ready = 1'b0;
    end
    if (acc) begin
      pend_valid = 1'b1;
      pend_pc    = drv_pc;
      if (drv_pc[1:0] != 2'b00) begin
        pend_ready = 1'b1;
        pend_exc   = 2'b01;
        pend_inst  = 32'h0000_0013;
      end else begin
        pend_ready   = 1'b0;
        req_expected = 1'b1;
        req_addr     = {drv_pc[63:3], 3'b000};
      end
    end
  endtask

  // Asynchronous assertion away from any clock edge; the memory forgets its work too.
  task automatic applyReset();
    @(negedge clock);
    clearDrive();
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    checkOutput("rst_mem_rsp_ready", bus.mem_rsp_ready, 1'b0);
    checkOutput("rst_id_valid", bus.id_valid, 1'b0);
    checkOutput("rst_mem_req_addr", bus.mem_req_addr, 64'h0);
    checkOutput("rst_id_pc", bus.id_pc, 64'h0);
    checkOutput("rst_id_inst", bus.id_inst, 32'h0);
    checkOutput("rst_id_exc", bus.id_exc, 2'b00);
    pend_valid   = 1'b0;
    pend_ready   = 1'b0;
    req_expected = 1'b0;
    mem_busy     = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic waitIdValid(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      applyStimulus();
      if (seen_idv) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic fetchOne(input logic [63:0] pc, output int lat);
    drv_pc_valid  = 1'b1;
    drv_pc        = pc;
    drv_id_ready  = 1'b0;
    drv_req_ready = 1'b1;
    applyStimulus();
    checkOutput("accept_ready", seen_ifr, 1'b1);
    drv_pc_valid = 1'b0;
    waitIdValid(12, lat);
  endtask

  task automatic handoff();
    drv_id_ready = 1'b1;
    applyStimulus();
    drv_id_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt;
    reset = 1'b1;
    clearDrive();
    applyReset();

    // Aligned fetch, upper half of the word, zero-wait memory.
    delay_cfg = 0;
    err_cfg   = 0;
    fetchOne(64'h8000_0004, lat);
    checkOutput("lat_aligned", lat, 3);
    checkOutput("ex_inst", bus.id_inst, 32'h00500093);
    checkOutput("ex_exc", bus.id_exc, 2'b00);
    handoff();

    fetchOne(64'h8000_0002, lat);
    checkOutput("lat_misaligned", lat, 1);
    checkOutput("mis_exc", bus.id_exc, 2'b01);
    checkOutput("mis_inst", bus.id_inst, 32'h0000_0013);
    handoff();

    err_cfg = 1;
    fetchOne(64'h8000_0000, lat);
    checkOutput("err_exc", bus.id_exc, 2'b10);
    checkOutput("err_pc", bus.id_pc, 64'h8000_0000);
    err_cfg = 0;
    handoff();

    // Flush while waiting; response shows up two cycles later.
    delay_cfg     = 2;
    drv_pc_valid  = 1'b1;
    drv_pc        = 64'h8000_1000;
    drv_req_ready = 1'b1;
    applyStimulus();
    drv_pc_valid = 1'b0;
    applyStimulus();
    drv_flush = 1'b1;
    applyStimulus();
    drv_flush = 1'b0;
    cnt = 0;
    repeat (5) begin
      applyStimulus();
      if (seen_idv) cnt++;
    end
    checkOutput("flush_wait_idv", cnt, 0);
    checkOutput("flush_wait_idle", seen_ifr, 1'b1);
    delay_cfg = 0;
    fetchOne(64'h8000_1008, lat);
    checkOutput("lat_after_flush", lat, 3);
    handoff();

    // Flush in REQ while memory stalls; the request must stay up.
    drv_pc_valid  = 1'b1;
    drv_pc        = 64'h8000_2004;
    drv_req_ready = 1'b0;
    applyStimulus();
    drv_pc_valid = 1'b0;
    drv_flush    = 1'b1;
    applyStimulus();
    drv_flush = 1'b0;
    applyStimulus();
    applyStimulus();
    drv_req_ready = 1'b1;
    cnt = 0;
    repeat (5) begin
      applyStimulus();
      if (seen_idv) cnt++;
    end
    checkOutput("flush_req_idv", cnt, 0);
    checkOutput("flush_req_idle", seen_ifr, 1'b1);

    // Decode stall, then handoff with a new PC accepted in the same cycle.
    fetchOne(64'h8000_3000, lat);
    repeat (4) applyStimulus();
    drv_id_ready = 1'b1;
    drv_pc_valid = 1'b1;
    drv_pc       = 64'h8000_300c;
    applyStimulus();
    checkOutput("handoff_accept", seen_ifr, 1'b1);
    drv_id_ready = 1'b0;
    drv_pc_valid = 1'b0;
    waitIdValid(12, lat);
    checkOutput("lat_back_to_back", lat, 3);

    // Flush in HOLD gates id_valid in that very cycle.
    drv_id_ready = 1'b1;
    drv_flush    = 1'b1;
    applyStimulus();
    checkOutput("flush_hold_idv", seen_idv, 1'b0);
    drv_flush    = 1'b0;
    drv_id_ready = 1'b0;
    applyStimulus();
    checkOutput("flush_hold_idle", seen_ifr, 1'b1);

    // Reset while a response is pending; a late response is then ignored.
    delay_cfg     = 5;
    drv_pc_valid  = 1'b1;
    drv_pc        = 64'h8000_4000;
    drv_req_ready = 1'b1;
    applyStimulus();
    drv_pc_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    applyReset();
    delay_cfg = 0;
    drv_stray = 1'b1;
    applyStimulus();
    drv_stray = 1'b0;
    checkOutput("stray_idv", seen_idv, 1'b0);
    fetchOne(64'h8000_4004, lat);
    checkOutput("lat_after_reset", lat, 3);
    handoff();

    delay_cfg = -1;
    err_cfg   = 2;
    for (int i = 0; i < 4000; i++) begin
      drv_pc_valid  = $urandom_range(0, 1);
      drv_pc        = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) drv_pc[1:0] = 2'b00;
      drv_flush     = ($urandom_range(0, 11) == 0);
      drv_id_ready  = ($urandom_range(0, 4) < 3);
      drv_req_ready = $urandom_range(0, 1);
      drv_stray     = ($urandom_range(0, 15) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ysyx_22040931_inst_fetch.md
YSYX_22040931_INST_FETCH -- requirements
Module: ysyx_22040931_inst_fetch

Interface
REQ-001 Parameter: PC_W, 64, PC and memory address width.
REQ-002 Parameter: BUS_W, 64, memory read-data width; fixed at 64.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 pc_valid  in  1  upstream PC stage offers a PC.
REQ-006 pc_in  in  PC_W  offered PC.
REQ-007 if_ready  out  1  this block accepts pc_in this cycle.
REQ-008 flush  in  1  pipeline redirect; kills all held and in-flight work.
REQ-009 mem_req_valid  out  1  read request valid.
REQ-010 mem_req_ready  in  1  memory accepts the request.
REQ-011 mem_req_addr  out  PC_W  8-byte-aligned read address.
REQ-012 mem_rsp_valid  in  1  read data valid.
REQ-013 mem_rsp_data  in  BUS_W  read data.
REQ-014 mem_rsp_err  in  1  access fault on this response.
REQ-015 mem_rsp_ready  out  1  block accepts the response.
REQ-016 id_valid  out  1  fetched instruction valid toward decode.
REQ-017 id_ready  in  1  decode accepts the instruction.
REQ-018 id_pc  out  PC_W  PC of the fetched instruction.
REQ-019 id_inst  out  32  fetched instruction.
REQ-020 id_exc  out  2  00 none, 01 misaligned PC, 10 access fault.

Function
REQ-021 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and DROP; a transfer on any handshake SHALL occur when valid and ready are both high at a rising edge.
REQ-022 if_ready SHALL be high in IDLE, and in HOLD when id_ready=1; it SHALL be forced low whenever flush=1.
REQ-023 An accepted PC SHALL be latched; if pc_in[1:0]!=0, the FSM SHALL go directly to HOLD with id_exc=01 and id_inst=32'h00000013, and SHALL issue no memory request; otherwise it SHALL go to REQ.
REQ-024 REQ: mem_req_valid=1 and mem_req_addr={pc[63:3],3'b000}, both held stable until mem_req_ready; on acceptance the FSM SHALL go to WAIT.
REQ-025 WAIT: mem_rsp_ready=1; on mem_rsp_valid, id_inst SHALL be mem_rsp_data[63:32] if pc[2]=1, else [31:0]; id_exc SHALL be 10 if mem_rsp_err=1 (id_inst is then don't-care); the FSM SHALL go to HOLD.
REQ-026 HOLD: id_valid=1; id_pc, id_inst and id_exc SHALL remain stable until id_ready; on id_ready, the FSM SHALL go to REQ or HOLD (per REQ-023) if a new PC is accepted in the same cycle, else to IDLE.
REQ-027 Minimum latency pc accept -> id_valid SHALL be 3 cycles with zero-wait memory (accept, request, response); the misaligned path SHALL take 1 cycle.
REQ-028 flush in IDLE: no effect.
REQ-029 flush in REQ: the request SHALL be kept asserted until accepted (no withdrawal), and then the FSM SHALL go to DROP; if mem_req_ready=1 in the flush cycle, it SHALL go to DROP directly.
REQ-030 flush in WAIT: if mem_rsp_valid=1 in the same cycle, the response SHALL be consumed and discarded and the FSM SHALL go to IDLE; otherwise it SHALL go to DROP.
REQ-031 flush after a request is accepted is remembered: a flush in REQ SHALL be latched in a kill flag, and that flag SHALL route the subsequent response to DROP handling.
REQ-032 DROP: mem_rsp_ready=1; on mem_rsp_valid, the data SHALL be discarded and the FSM SHALL go to IDLE; id_valid SHALL be 0 throughout.
REQ-033 flush in HOLD: id_valid SHALL be 0 in that cycle (combinationally gated), and the FSM SHALL go to IDLE.
REQ-034 At most one memory request SHALL be outstanding at any time.
REQ-035 mem_rsp_valid outside WAIT or DROP SHALL be ignored, and mem_rsp_ready SHALL be 0 there.

Reset
REQ-036 While reset=0, regardless of clock: state SHALL be IDLE; kill flag, id_valid, mem_req_valid and mem_rsp_ready SHALL be 0; id_pc, id_inst, mem_req_addr and id_exc SHALL be all zeros.
REQ-037 Reset asserted mid-transaction SHALL abandon any outstanding request without draining it; a response arriving after reset release SHALL be ignored per REQ-035.

Verification
REQ-038 pc_in=0x80000004, zero-wait memory with data 0x00500093_00100073 -> mem_req_addr=0x80000000, id_inst=0x00500093, id_exc=00, id_valid 3 cycles after accept.
REQ-039 pc_in=0x80000002 -> no mem_req_valid, next cycle id_valid=1, id_exc=01, id_inst=0x00000013.
REQ-040 Response with mem_rsp_err=1 for pc 0x80000000 -> id_valid with id_exc=10, id_pc=0x80000000.
REQ-041 flush while in WAIT, response 2 cycles later -> id_valid stays 0, the FSM reaches IDLE after the response, and the next PC is fetched normally.
REQ-042 flush in REQ with mem_req_ready=0 for 3 cycles -> mem_req_valid and the address stay stable, the response is discarded, and no id_valid occurs.
REQ-043 id_ready held 0 for 4 cycles in HOLD, then 1 with pc_valid=1 -> outputs stable during the stall, and the next PC is accepted in the same cycle as the handoff.
